// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// The op encoding is {wr_acc, rd_acc}.
package fifo_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_RW    = 2'b11
   } fifo_op_e;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, status and sticky-error control for fifo_sync_param.
// Acceptance decisions are exported so the top can gate the storage.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr,
   input  logic                  clr_err,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  wr_acc,
   output logic                  rd_acc,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CW    = ADDR_WIDTH + 1;
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [ADDR_WIDTH-1:0] P_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0] C_ONE   = CW'(1);

   if (ADDR_WIDTH < 1) begin : g_bad_aw
      $error("fifo_ptr_ctrl: ADDR_WIDTH must be >= 1");
   end
   if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_ptr_ctrl: AF_LEVEL outside 0..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
      $error("fifo_ptr_ctrl: AE_LEVEL outside 0..DEPTH");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_ok;
   logic                  rd_ok;
   fifo_op_e              op;

   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_empty = (count_q <= AE_C);
   assign almost_full  = (count_q >= AF_C);

   // A read on a full FIFO frees the slot for a same-cycle write.
   assign wr_ok  = wr & (~full | rd);
   assign rd_ok  = rd & ~empty;
   // Flush wins: nothing is transferred or flagged in that cycle.
   assign wr_acc = wr_ok & ~clr;
   assign rd_acc = rd_ok & ~clr;
   assign op     = fifo_op_e'({wr_acc, rd_acc});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      unique case (op)
         OP_WRITE: begin
            wr_ptr_d = wr_ptr_q + P_ONE;
            count_d  = count_q + C_ONE;
         end
         OP_READ: begin
            rd_ptr_d = rd_ptr_q + P_ONE;
            count_d  = count_q - C_ONE;
         end
         OP_RW: begin
            wr_ptr_d = wr_ptr_q + P_ONE;
            rd_ptr_d = rd_ptr_q + P_ONE;
         end
         OP_NONE: begin
            count_d = count_q;
         end
      endcase
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // A new error outranks a simultaneous clear request.
   always_comb begin
      ovf_d = (ovf_q & ~clr_err) | (wr & ~wr_ok & ~clr);
      udf_d = (udf_q & ~clr_err) | (rd & ~rd_ok & ~clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign w_addr    = wr_ptr_q;
   assign r_addr    = rd_ptr_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with register-file storage and programmable thresholds.
// Define FIFO_FWFT_EN for first-word fall-through; default is registered read.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] r_data,
   input  logic                  clr,
   input  logic                  clr_err,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   fifo_ptr_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
   ) u_ctrl (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr           (wr),
      .rd           (rd),
      .clr          (clr),
      .clr_err      (clr_err),
      .w_addr       (w_addr),
      .r_addr       (r_addr),
      .wr_acc       (wr_acc),
      .rd_acc       (rd_acc),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Storage is not reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (wr_acc && reset_n) begin
         mem_q[w_addr] <= w_data;
      end
   end

`ifdef FIFO_FWFT_EN
   assign r_data = mem_q[r_addr];
`else
   logic [DATA_WIDTH-1:0] r_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_q <= '0;
      end else if (rd_acc) begin
         r_data_q <= mem_q[r_addr];
      end
   end

   assign r_data = r_data_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param, default registered read.
// DEPTH = 8, AF_LEVEL = 7, AE_LEVEL = 1.
module tb_fifo_sync_param;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr;
   logic [7:0] w_data;
   logic       rd;
   logic [7:0] r_data;
   logic       clr;
   logic       clr_err;
   logic       empty;
   logic       full;
   logic       almost_empty;
   logic       almost_full;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q [$];

   fifo_sync_param dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr           (wr),
      .w_data       (w_data),
      .rd           (rd),
      .r_data       (r_data),
      .clr          (clr),
      .clr_err      (clr_err),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [7:0] wd, input logic r,
                        input logic c, input logic ce);
      wr      = w;
      w_data  = wd;
      rd      = r;
      clr     = c;
      clr_err = ce;
      @(posedge clk);
      #1;
      wr      = 1'b0;
      rd      = 1'b0;
      clr     = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_ae"}, almost_empty, 1);
      chk({tag, "_af"}, almost_full, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_udf"}, underflow, 0);
      chk({tag, "_rdata"}, r_data, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      wr      = 1'b0;
      w_data  = '0;
      rd      = 1'b0;
      clr     = 1'b0;
      clr_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // fill 0x11..0x18
      for (int i = 0; i < 8; i++) begin
         drive(1, 8'(8'h11 + i), 0, 0, 0);
         chk("fill_cnt", count, i + 1);
         chk("fill_af", almost_full, (i + 1 >= 7));
         chk("fill_full", full, (i == 7));
         chk("fill_empty", empty, 0);
      end
      chk("fill_ovf0", overflow, 0);
      drive(1, 8'h99, 0, 0, 0);
      chk("ovf_set", overflow, 1);
      chk("ovf_cnt", count, 8);

      // drain in order
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, 0, 0);
         chk("drain_data", r_data, 8'h11 + i);
         chk("drain_cnt", count, 7 - i);
         chk("drain_ae", almost_empty, (7 - i <= 1));
      end
      chk("drain_empty", empty, 1);
      chk("drain_udf0", underflow, 0);
      drive(0, 0, 1, 0, 0);
      chk("udf_set", underflow, 1);
      chk("udf_hold", r_data, 8'h18);
      chk("udf_cnt", count, 0);

      drive(0, 0, 0, 0, 1);
      chk("clrerr_ovf", overflow, 0);
      chk("clrerr_udf", underflow, 0);

      // full + simultaneous wr/rd
      for (int i = 0; i < 8; i++) drive(1, 8'(8'h21 + i), 0, 0, 0);
      chk("full2", full, 1);
      drive(1, 8'hA5, 1, 0, 0);
      chk("frw_cnt", count, 8);
      chk("frw_data", r_data, 8'h21);
      chk("frw_ovf", overflow, 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, 0, 0);
         chk("frw_drain", r_data, (i == 7) ? 8'hA5 : 8'(8'h22 + i));
      end
      chk("frw_empty", empty, 1);

      // empty + simultaneous wr/rd: write only
      drive(1, 8'h3C, 1, 0, 0);
      chk("erw_udf", underflow, 1);
      chk("erw_cnt", count, 1);
      chk("erw_hold", r_data, 8'hA5);
      drive(0, 0, 1, 0, 0);
      chk("erw_data", r_data, 8'h3C);
      chk("erw_cnt2", count, 0);
      drive(0, 0, 0, 0, 1);

      // 20 writes / 20 reads, pointers wrap twice
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'(8'h40 + i), 0, 0, 0);
         exp_q.push_back(8'(8'h40 + i));
      end
      for (int i = 3; i < 20; i++) begin
         drive(1, 8'(8'h40 + i), 1, 0, 0);
         exp_q.push_back(8'(8'h40 + i));
         chk("wrap_data", r_data, exp_q.pop_front());
         chk("wrap_cnt", count, 3);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 0);
         chk("wrap_tail", r_data, exp_q.pop_front());
      end
      chk("wrap_empty", empty, 1);
      chk("wrap_flags", {overflow, underflow}, 2'b00);

      // flush keeps flags; flush-cycle wr/rd neither done nor flagged
      for (int i = 0; i < 8; i++) drive(1, 8'(8'h60 + i), 0, 0, 0);
      drive(1, 8'hEE, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
      chk("pre_clr_cnt", count, 5);
      chk("pre_clr_data", r_data, 8'h62);
      drive(1, 8'h77, 1, 1, 0);
      chk("clr_cnt", count, 0);
      chk("clr_empty", empty, 1);
      chk("clr_ovf", overflow, 1);
      chk("clr_udf", underflow, 0);
      chk("clr_data", r_data, 8'h62);
      drive(0, 0, 0, 0, 1);
      chk("clrerr2", {overflow, underflow}, 2'b00);

      // clr_err and a new error in the same cycle: set wins
      drive(0, 0, 1, 0, 1);
      chk("set_wins", underflow, 1);

      // reset mid-write
      drive(1, 8'h5A, 0, 0, 0);
      drive(1, 8'h5B, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      chk("pre_rst_data", r_data, 8'h5A);
      chk("pre_rst_cnt", count, 1);
      wr     = 1'b1;
      w_data = 8'hC3;
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async");
      wr = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 8'h99, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      chk("post_rst_data", r_data, 8'h99);
      chk("post_rst_empty", empty, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO with integrated register-file storage. It supersedes the pointer-only FIFO controller used in the UART datapath. Over that controller it adds:
- configurable depth and width
- programmable almost-full/almost-empty thresholds
- an occupancy count output
- sticky overflow/underflow error flags
- a synchronous flush
- a compile-time choice of read mode

It sits between the UART receiver/transmitter and the bus-side register interface.

## Interface
- ADDR_WIDTH, 3: address bits; depth DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 8: word width in bits
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr  in  1  write request
- w_data  in  DATA_WIDTH  write data, sampled on an accepted write
- rd  in  1  read request
- r_data  out  DATA_WIDTH  read data (timing per read mode)
- clr  in  1  synchronous flush; empties the FIFO
- clr_err  in  1  synchronous clear of the sticky error flags
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- State is held in these registers: wr_ptr and rd_ptr (ADDR_WIDTH bits each), count (ADDR_WIDTH+1 bits), overflow, underflow, r_data (standard mode only), and the memory array mem[DEPTH].
- Write acceptance: wr_acc = wr & (~full | rd).
  - When full, a simultaneous read frees the slot, so the write is accepted in the same cycle.
- Read acceptance: rd_acc = rd & ~empty.
  - When empty, a simultaneous write is accepted but the read is not. There is no bypass path.
- On wr_acc: mem[wr_ptr] <= w_data and wr_ptr increments.
- On rd_acc: rd_ptr increments.
- Pointers wrap modulo DEPTH naturally.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- Error flags:
  - wr & ~wr_acc sets overflow.
  - rd & ~rd_acc sets underflow.
  - Both flags clear only on clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- Flush: clr zeroes wr_ptr, rd_ptr and count, and takes priority over wr and rd in the same cycle.
  - A write or read in the flush cycle is neither performed nor flagged.
  - Memory contents are not cleared.
  - Error flags are unaffected by clr.
- All status outputs are decoded combinationally from the registered count, so they are glitch-free relative to clk.

## Timing
- Reset (reset_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0
  - almost_empty = 1 (when AE_LEVEL >= 0), almost_full = 0
  - overflow = underflow = 0, r_data = 0
  - Memory is not reset.
- Reset asserted mid-operation aborts any transfer in progress in that cycle. Reset release is synchronous to clk.
- Status latency: count and all flags reflect an accepted operation one edge after that edge.
  - Example: a write at edge N deasserts empty after edge N.
- Standard read mode: r_data is registered and loads mem[rd_ptr] at the edge where rd_acc is true.
  - Data is valid from that edge and held until the next accepted read.
  - Read latency is 1 cycle.
- Back-to-back: sustained wr and rd at 1 word per cycle each, with no bubbles at any fill level from 1 to DEPTH-1.
- Threshold parameters outside 0..DEPTH are illegal. An elaboration-time assertion must fire on them.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through.
  - r_data = mem[rd_ptr] combinationally; no output register.
  - The head word is valid whenever empty = 0.
  - rd acknowledges (pops) the presented word.
  - A word written into an empty FIFO appears on r_data one cycle after the write edge.
- FIFO_FWFT_EN undefined: standard registered read with 1-cycle latency, as described under Timing.

## Structure
- Package fifo_pkg holds:
  - the op enum {OP_NONE, OP_READ, OP_WRITE, OP_RW}, decoded from {wr_acc, rd_acc}
  - a function computing DEPTH from ADDR_WIDTH
- Sub-module fifo_ptr_ctrl contains pointers, count, acceptance logic, flags and errors. Its outputs are w_addr, r_addr, wr_acc and rd_acc.
- The top level instantiates fifo_ptr_ctrl and holds the memory array plus the r_data path.

## Test plan
- Reset, then write 0x11..0x18 (DEPTH=8) → count steps 1..8; almost_full at count 7; full at 8. A 9th write is rejected: overflow = 1, count stays 8.
- Read all 8 words → data 0x11..0x18 in order; empty after the last read. One extra read → underflow = 1 and r_data holds 0x18 (standard mode).
- Fill to 8, then assert wr and rd together with w_data = 0xA5 → both accepted, count stays 8. Drain order ends with 0xA5.
- With the FIFO empty, assert wr and rd together with 0x3C → write only, underflow = 1, count = 1. A following read returns 0x3C.
- 20 writes interleaved with 20 reads → pointers wrap twice, no data loss, count never exceeds DEPTH.
- Fill to 5 → pulse clr → count = 0, empty = 1, overflow unchanged. Pulse clr_err → flags = 0. Drop reset_n mid-write → all outputs return to reset values immediately.
